// File: rtl/secret_pkg.sv
// secret_pkg -- shared constants, types and helpers for secret_accum.
//
// Contents:
//   SECRET_VALUE_DEFAULT / ACCUM_W_DEFAULT : default parameter values
//   S*_W                                   : loopback port widths
//   s4x32_t                                : packed 4x32 loopback type
//   fold32 / rotl1                         : signature helpers used by secret_sig
package secret_pkg;

  localparam int SECRET_VALUE_DEFAULT = 7;
  localparam int ACCUM_W_DEFAULT      = 32;

  localparam int S1_W   = 1;
  localparam int S2_W   = 2;
  localparam int S8_W   = 8;
  localparam int S33_W  = 33;
  localparam int S64_W  = 64;
  localparam int S65_W  = 65;
  localparam int S129_W = 129;

  localparam int CYC_W = 32;
  localparam int SIG_W = 32;

  // Every loopback input is zero-extended to this width before folding;
  // 160 is the smallest multiple of 32 that holds the 129-bit port.
  localparam int FOLD_W = 160;

  typedef logic [3:0][31:0] s4x32_t;

  // XOR of consecutive 32-bit slices; the caller zero-extends the operand,
  // which makes the last partial slice zero-extended as well.
  function automatic logic [SIG_W-1:0] fold32(input logic [FOLD_W-1:0] v);
    logic [SIG_W-1:0] r;
    r = '0;
    for (int i = 0; i < FOLD_W / SIG_W; i++) begin
      r = r ^ v[i*SIG_W +: SIG_W];
    end
    return r;
  endfunction

  function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
    return {v[SIG_W-2:0], v[SIG_W-1]};
  endfunction

endpackage

// File: rtl/secret_sig.sv
// secret_sig -- running signature over the loopback inputs.
//
// Built only when SECRET_ACCUM_SIG_EN is defined.
//
// Each rising edge: sig <= rotl(sig, 1) ^ (fold32 of every loopback input,
// each input folded on its own and the results XORed together).
//
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset, clears sig
//   s1 .. s129     : loopback inputs (1/2/8/33/64/65/129 bits)
//   s4x32          : packed 4x32 loopback input
//   sig            : registered 32-bit signature
`ifdef SECRET_ACCUM_SIG_EN
module secret_sig
  import secret_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [S1_W-1:0]     s1,
  input  logic [S2_W-1:0]     s2,
  input  logic [S8_W-1:0]     s8,
  input  logic [S33_W-1:0]    s33,
  input  logic [S64_W-1:0]    s64,
  input  logic [S65_W-1:0]    s65,
  input  logic [S129_W-1:0]   s129,
  input  s4x32_t              s4x32,
  output logic [SIG_W-1:0]    sig
);

  logic [SIG_W-1:0] fold_all;

  always_comb begin
    fold_all = '0;
    fold_all = fold32(FOLD_W'(s1))
             ^ fold32(FOLD_W'(s2))
             ^ fold32(FOLD_W'(s8))
             ^ fold32(FOLD_W'(s33))
             ^ fold32(FOLD_W'(s64))
             ^ fold32(FOLD_W'(s65))
             ^ fold32(FOLD_W'(s129))
             ^ fold32(FOLD_W'(s4x32));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else begin
      sig <= rotl1(sig) ^ fold_all;
    end
  end

endmodule
`endif

// File: rtl/secret_accum.sv
// secret_accum -- running accumulator with a constant addend, a bypass mux,
// pass-through loopback ports and a saturating edge counter.
//
// Optional feature: define SECRET_ACCUM_SIG_EN to add the sig_out port and
// the secret_sig signature register. Without it sig_out does not exist and
// everything else behaves the same.
//
// Parameters:
//   SECRET_VALUE : constant added to the accumulator every edge
//   ACCUM_W      : accumulator width (sum wraps modulo 2^ACCUM_W)
//
// Ports:
//   clk               : clock, all state changes on the rising edge
//   rst_n             : asynchronous active-low reset
//   accum_in          : per-edge addend
//   accum_out         : registered running sum
//   accum_bypass      : 1 selects accum_in onto accum_bypass_out
//   accum_bypass_out  : accum_bypass ? accum_in : accum_out (combinational)
//   s*_in / s*_out    : combinational loopbacks, bit-exact
//   cyc_out           : edges since reset release, saturates at all-ones
//   sig_out           : loopback signature (SECRET_ACCUM_SIG_EN only)
module secret_accum
  import secret_pkg::*;
#(
  parameter int SECRET_VALUE = SECRET_VALUE_DEFAULT,
  parameter int ACCUM_W      = ACCUM_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ACCUM_W-1:0]  accum_in,
  output logic [ACCUM_W-1:0]  accum_out,
  input  logic                accum_bypass,
  output logic [ACCUM_W-1:0]  accum_bypass_out,
  input  logic [S1_W-1:0]     s1_in,
  output logic [S1_W-1:0]     s1_out,
  input  logic [S2_W-1:0]     s2_in,
  output logic [S2_W-1:0]     s2_out,
  input  logic [S8_W-1:0]     s8_in,
  output logic [S8_W-1:0]     s8_out,
  input  logic [S33_W-1:0]    s33_in,
  output logic [S33_W-1:0]    s33_out,
  input  logic [S64_W-1:0]    s64_in,
  output logic [S64_W-1:0]    s64_out,
  input  logic [S65_W-1:0]    s65_in,
  output logic [S65_W-1:0]    s65_out,
  input  logic [S129_W-1:0]   s129_in,
  output logic [S129_W-1:0]   s129_out,
  input  s4x32_t              s4x32_in,
  output s4x32_t              s4x32_out,
  output logic [CYC_W-1:0]    cyc_out
`ifdef SECRET_ACCUM_SIG_EN
  ,
  output logic [SIG_W-1:0]    sig_out
`endif
);

  localparam logic [ACCUM_W-1:0] SECRET_ADD = ACCUM_W'(SECRET_VALUE);

  // Accumulator: the carry out of the top bit is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_out <= '0;
    end else begin
      accum_out <= accum_out + accum_in + SECRET_ADD;
    end
  end

  // Edge counter holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_out <= '0;
    end else if (cyc_out != '1) begin
      cyc_out <= cyc_out + CYC_W'(1);
    end
  end

  // Bypass select only steers this output; it never gates accumulation.
  always_comb begin
    accum_bypass_out = accum_out;
    if (accum_bypass) begin
      accum_bypass_out = accum_in;
    end
  end

  assign s1_out    = s1_in;
  assign s2_out    = s2_in;
  assign s8_out    = s8_in;
  assign s33_out   = s33_in;
  assign s64_out   = s64_in;
  assign s65_out   = s65_in;
  assign s129_out  = s129_in;
  assign s4x32_out = s4x32_in;

`ifdef SECRET_ACCUM_SIG_EN
  secret_sig u_sig (
    .clk   (clk),
    .rst_n (rst_n),
    .s1    (s1_in),
    .s2    (s2_in),
    .s8    (s8_in),
    .s33   (s33_in),
    .s64   (s64_in),
    .s65   (s65_in),
    .s129  (s129_in),
    .s4x32 (s4x32_in),
    .sig   (sig_out)
  );
`endif

endmodule

// File: tb/tb_secret_accum.sv
// tb_secret_accum -- directed bench for secret_accum.
//
// Instance a: default parameters (SECRET_VALUE=7, ACCUM_W=32).
// Instance b: SECRET_VALUE=3, ACCUM_W=16, own reset and own wide loopback
// inputs, so the two run independently.
// Define SECRET_ACCUM_SIG_EN to also exercise sig_out on instance a.
module tb_secret_accum;
  import secret_pkg::*;

  localparam int CW = 160;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance a signals ----------------
  logic [31:0]  accum_in  = '0;
  logic [31:0]  accum_out;
  logic         accum_bypass = 1'b0;
  logic [31:0]  accum_bypass_out;
  logic [0:0]   s1_in  = '0;
  logic [1:0]   s2_in  = '0;
  logic [7:0]   s8_in  = '0;
  logic [32:0]  s33_in = '0;
  logic [63:0]  s64_in = '0;
  logic [64:0]  s65_in = '0;
  logic [128:0] s129_in = '0;
  s4x32_t       s4x32_in = '0;
  logic [0:0]   s1_out;
  logic [1:0]   s2_out;
  logic [7:0]   s8_out;
  logic [32:0]  s33_out;
  logic [63:0]  s64_out;
  logic [64:0]  s65_out;
  logic [128:0] s129_out;
  s4x32_t       s4x32_out;
  logic [31:0]  cyc_out;
`ifdef SECRET_ACCUM_SIG_EN
  logic [31:0]  sig_out;
`endif

  // ---------------- instance b signals ----------------
  logic [15:0]  accum_in_b = '0;
  logic [15:0]  accum_out_b;
  logic [15:0]  accum_bypass_out_b;
  logic [128:0] s129_in_b = '0;
  s4x32_t       s4x32_in_b = '0;
  logic [0:0]   s1_out_b;
  logic [1:0]   s2_out_b;
  logic [7:0]   s8_out_b;
  logic [32:0]  s33_out_b;
  logic [63:0]  s64_out_b;
  logic [64:0]  s65_out_b;
  logic [128:0] s129_out_b;
  s4x32_t       s4x32_out_b;
  logic [31:0]  cyc_out_b;
`ifdef SECRET_ACCUM_SIG_EN
  logic [31:0]  sig_out_b;
`endif

  secret_accum u_dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .accum_in         (accum_in),
    .accum_out        (accum_out),
    .accum_bypass     (accum_bypass),
    .accum_bypass_out (accum_bypass_out),
    .s1_in            (s1_in),
    .s1_out           (s1_out),
    .s2_in            (s2_in),
    .s2_out           (s2_out),
    .s8_in            (s8_in),
    .s8_out           (s8_out),
    .s33_in           (s33_in),
    .s33_out          (s33_out),
    .s64_in           (s64_in),
    .s64_out          (s64_out),
    .s65_in           (s65_in),
    .s65_out          (s65_out),
    .s129_in          (s129_in),
    .s129_out         (s129_out),
    .s4x32_in         (s4x32_in),
    .s4x32_out        (s4x32_out),
    .cyc_out          (cyc_out)
`ifdef SECRET_ACCUM_SIG_EN
    ,
    .sig_out          (sig_out)
`endif
  );

  secret_accum #(
    .SECRET_VALUE (3),
    .ACCUM_W      (16)
  ) u_dut_b (
    .clk              (clk),
    .rst_n            (rst_b),
    .accum_in         (accum_in_b),
    .accum_out        (accum_out_b),
    .accum_bypass     (1'b0),
    .accum_bypass_out (accum_bypass_out_b),
    .s1_in            (s1_in),
    .s1_out           (s1_out_b),
    .s2_in            (s2_in),
    .s2_out           (s2_out_b),
    .s8_in            (s8_in),
    .s8_out           (s8_out_b),
    .s33_in           (s33_in),
    .s33_out          (s33_out_b),
    .s64_in           (s64_in),
    .s64_out          (s64_out_b),
    .s65_in           (s65_in),
    .s65_out          (s65_out_b),
    .s129_in          (s129_in_b),
    .s129_out         (s129_out_b),
    .s4x32_in         (s4x32_in_b),
    .s4x32_out        (s4x32_out_b),
    .cyc_out          (cyc_out_b)
`ifdef SECRET_ACCUM_SIG_EN
    ,
    .sig_out          (sig_out_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [CW-1:0] observed,
                       input logic [CW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [31:0] v);
    accum_in = v;
  endtask

  // Step once and check accum_out against the head of the expected queue.
  task automatic step_and_pop(input string tag);
    logic [31:0] e;
    step();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, CW'(accum_out), CW'(e));
    end
  endtask

  logic [CW-1:0] rnd;

  task automatic randomize_loopback();
    rnd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s129_in  = rnd[128:0];
    rnd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s4x32_in = rnd[127:0];
    rnd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s129_in_b = rnd[128:0];
    rnd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s4x32_in_b = rnd[127:0];
    rnd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s1_in    = rnd[0:0];
    s2_in    = rnd[2:1];
    s8_in    = rnd[10:3];
    s33_in   = rnd[43:11];
    s64_in   = rnd[107:44];
    rnd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s65_in   = rnd[64:0];
  endtask

  task automatic zero_loopback();
    s1_in = '0; s2_in = '0; s8_in = '0; s33_in = '0; s64_in = '0;
    s65_in = '0; s129_in = '0; s4x32_in = '0; s129_in_b = '0; s4x32_in_b = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Held in reset across edges: everything reads zero.
    step();
    step();
    check("reset_accum", CW'(accum_out), CW'(32'd0));
    check("reset_cyc", CW'(cyc_out), CW'(32'd0));
    check("reset_bypass0", CW'(accum_bypass_out), CW'(32'd0));
    // Bypass mux still live during reset.
    accum_bypass = 1'b1;
    drive_a(32'h0000_1234);
    #1;
    check("reset_bypass1", CW'(accum_bypass_out), CW'(32'h0000_1234));
    step();
    check("reset_hold_accum", CW'(accum_out), CW'(32'd0));
    accum_bypass = 1'b0;
    drive_a(32'd0);

    // Release between edges, then accumulate 0, 5, 10 -> 7, 19, 36.
    rst_n = 1'b1;
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd19);
    exp_q.push_back(32'd36);
    drive_a(32'd0);  step_and_pop("acc_1");
    check("cyc_1", CW'(cyc_out), CW'(32'd1));
    drive_a(32'd5);  step_and_pop("acc_2");
    drive_a(32'd10); step_and_pop("acc_3");
    check("cyc_3", CW'(cyc_out), CW'(32'd3));

    // Mid-run reset pulse between edges clears asynchronously.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_accum", CW'(accum_out), CW'(32'd0));
    check("midrst_cyc", CW'(cyc_out), CW'(32'd0));
    #1;
    rst_n = 1'b1;

    // Rebuild to 36; counter restarts from the release.
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd19);
    exp_q.push_back(32'd36);
    drive_a(32'd0);  step_and_pop("reacc_1");
    drive_a(32'd5);  step_and_pop("reacc_2");
    drive_a(32'd10); step_and_pop("reacc_3");
    check("recyc_3", CW'(cyc_out), CW'(32'd3));

    // Bypass: selected input appears immediately, accumulation unaffected.
    accum_bypass = 1'b1;
    drive_a(32'd25);
    #1;
    check("bypass_same_cycle", CW'(accum_bypass_out), CW'(32'd25));
    exp_q.push_back(32'd68);
    step_and_pop("bypass_accum");
    check("bypass_after_edge", CW'(accum_bypass_out), CW'(32'd25));
    accum_bypass = 1'b0;
    #1;
    check("bypass_off", CW'(accum_bypass_out), CW'(32'd68));

    // Wrap: 68 + 0xFFFFFFA5 + 7 = 0xFFFFFFF0, then + 9 + 7 = 0 (mod 2^32).
    exp_q.push_back(32'hFFFF_FFF0);
    exp_q.push_back(32'h0000_0000);
    drive_a(32'hFFFF_FFA5); step_and_pop("wrap_pre");
    drive_a(32'd9);         step_and_pop("wrap_zero");
    check("cyc_6", CW'(cyc_out), CW'(32'd6));

    // Instance b: 16-bit datapath, SECRET_VALUE=3, independent reset.
    check("b_reset_accum", CW'(accum_out_b), CW'(16'd0));
    check("b_reset_cyc", CW'(cyc_out_b), CW'(32'd0));
    rst_b = 1'b1;
    accum_in_b = 16'hFFF0;
    step();
    check("b_acc_1", CW'(accum_out_b), CW'(16'hFFF3));
    check("b_bypass_out", CW'(accum_bypass_out_b), CW'(16'hFFF3));
    accum_in_b = 16'h000A;
    step();
    check("b_wrap", CW'(accum_out_b), CW'(16'h0000));
    check("b_cyc_2", CW'(cyc_out_b), CW'(32'd2));

    // Loopbacks on both instances with fresh random data every cycle.
    for (int i = 0; i < 6; i++) begin
      randomize_loopback();
      #1;
      check("lb_a_s1", CW'(s1_out), CW'(s1_in));
      check("lb_a_s2", CW'(s2_out), CW'(s2_in));
      check("lb_a_s8", CW'(s8_out), CW'(s8_in));
      check("lb_a_s33", CW'(s33_out), CW'(s33_in));
      check("lb_a_s64", CW'(s64_out), CW'(s64_in));
      check("lb_a_s65", CW'(s65_out), CW'(s65_in));
      check("lb_a_s129", CW'(s129_out), CW'(s129_in));
      check("lb_a_s4x32", CW'(s4x32_out), CW'(s4x32_in));
      check("lb_b_s8", CW'(s8_out_b), CW'(s8_in));
      check("lb_b_s65", CW'(s65_out_b), CW'(s65_in));
      check("lb_b_s129", CW'(s129_out_b), CW'(s129_in_b));
      check("lb_b_s4x32", CW'(s4x32_out_b), CW'(s4x32_in_b));
      step();
    end
    zero_loopback();

`ifdef SECRET_ACCUM_SIG_EN
    // Signature: fresh reset, one edge of s8=0xA5 then zero inputs.
    #1;
    rst_n = 1'b0;
    #1;
    check("sig_reset", CW'(sig_out), CW'(32'd0));
    rst_n = 1'b1;
    s8_in = 8'hA5;
    step();
    check("sig_a5", CW'(sig_out), CW'(32'h0000_00A5));
    s8_in = 8'h00;
    step();
    check("sig_rot1", CW'(sig_out), CW'(32'h0000_014A));
    step();
    check("sig_rot2", CW'(sig_out), CW'(32'h0000_0294));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/secret_accum.md
SECRET_ACCUM -- requirements
Module: secret_accum

Interface
REQ-001 SHALL provide parameter SECRET_VALUE, default 7: constant added to the accumulator every cycle.
REQ-002 SHALL provide parameter ACCUM_W, default 32: accumulator datapath width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port accum_in  input  ACCUM_W  addend per cycle.
REQ-006 SHALL have port accum_out  output  ACCUM_W  registered running sum.
REQ-007 SHALL have port accum_bypass  input  1  selects accum_in onto accum_bypass_out.
REQ-008 SHALL have port accum_bypass_out  output  ACCUM_W  bypass-muxed result.
REQ-009 SHALL have ports s1/s2/s8/s33/s64/s65/s129 _in (input) and _out (output), widths 1/2/8/33/64/65/129; loopback data.
REQ-010 SHALL have ports s4x32_in  input  packed 4x32  and s4x32_out  output  packed 4x32; loopback data.
REQ-011 SHALL have port cyc_out  output  32  count of clock edges since reset release.
REQ-012 SHALL have port sig_out  output  32  loopback-data signature (only when SECRET_ACCUM_SIG_EN is defined).

Function
REQ-013 SHALL update accum_out <= accum_out + accum_in + SECRET_VALUE on every rising clk edge while rst_n is high.
REQ-014 SHALL truncate the sum to ACCUM_W bits (modulo 2^ACCUM_W wrap) with no carry or overflow flag.
REQ-015 SHALL drive accum_bypass_out combinationally: accum_in when accum_bypass=1, else accum_out; zero latency.
REQ-016 SHALL drive every s*_out combinationally equal to its s*_in, bit-exact, zero latency, with no width change.
REQ-017 SHALL increment cyc_out by 1 per edge, saturating at 0xFFFFFFFF (no wrap).
REQ-018 SHALL update sig_out each edge as sig_out <= rotl(sig_out,1) XOR fold32(all s*_in), where fold32 XORs consecutive 32-bit slices (last slice zero-extended).
REQ-019 SHALL take the accum_in value present at the edge into accum_out, including a change to accum_bypass on the same edge; the bypass select does not affect accumulation.

Reset
REQ-020 SHALL clear accum_out, cyc_out and sig_out to 0 immediately on rst_n falling, independent of clk.
REQ-021 SHALL hold all registers at 0 while rst_n is low; first accumulation occurs on the first rising edge with rst_n high.
REQ-022 SHALL keep the combinational outputs (bypass mux, loopbacks) functional during reset; with accum_bypass=0, accum_bypass_out reads 0.

Configuration
REQ-023 SHALL compile the signature register, sig_out port and secret_sig sub-module only when SECRET_ACCUM_SIG_EN is defined.
REQ-024 SHALL, without SECRET_ACCUM_SIG_EN, omit sig_out entirely; all other behaviour is identical.

Structure
REQ-025 SHALL place SECRET_VALUE_DEFAULT, ACCUM_W_DEFAULT, the loopback widths and typedef s4x32_t (logic [3:0][31:0]) in package secret_pkg.
REQ-026 SHALL implement fold and rotate in one sub-module, secret_sig (registered, async active-low reset), instantiated only under SECRET_ACCUM_SIG_EN.

Verification
REQ-027 Accumulate: reset, release, accum_in=0,5,10 on three edges -> accum_out=7, 19, 36.
REQ-028 Bypass: accum_out=36, accum_bypass=1, accum_in=25 -> accum_bypass_out=25 same cycle; the next edge sets accum_out=68.
REQ-029 Wrap: accum_out=0xFFFFFFF0, accum_in=9 -> accum_out=0x00000000 after one edge.
REQ-030 Mid-run reset: accum_out=36, cyc_out=3, pulse rst_n low between edges -> accum_out=0 and cyc_out=0 before the next edge.
REQ-031 Loopback: drive random 129-bit s129_in and random s4x32_in each cycle -> outputs equal inputs every cycle; two instances run independently.
REQ-032 Signature (SIG_EN defined): after reset, s8_in=0xA5 and all other inputs 0 for one edge -> sig_out=0x000000A5; the next edge with all inputs 0 -> 0x0000014A.
